// File: rtl/sdft_pkg.sv
// Shared types and width helpers for the sliding-DFT scheduler slice.
package sdft_pkg;

  localparam int unsigned DEF_WORD_WIDTH = 16;
  localparam int unsigned DEF_FFT_SIZE   = 256;
  localparam int unsigned DEF_FRAME_HOP  = 64;

  localparam int unsigned ADDR_W = $clog2(DEF_FFT_SIZE);
  localparam int unsigned DIFF_W = DEF_WORD_WIDTH + 1;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    FETCH,
    WAIT_UPD,
    READOUT
  } state_e;

  function automatic int unsigned addr_width(input int unsigned fft_size);
    return $clog2(fft_size);
  endfunction

  function automatic int unsigned diff_width(input int unsigned word_width);
    return word_width + 1;
  endfunction

endpackage

// File: rtl/sdft_sweep_counter.sv
// 0..DEPTH-1 address sweep shared by the ring/bin clear and the frame readout.
module sdft_sweep_counter #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  output logic          active_o,
  output logic [AW-1:0] count_o,
  output logic          last_o
);

  logic          active_q;
  logic [AW-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      count_q  <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      count_q  <= '0;
    end else if (active_q) begin
      if (count_q == AW'(DEPTH - 1)) begin
        active_q <= 1'b0;
        count_q  <= '0;
      end else begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign active_o = active_q;
  assign count_o  = count_q;
  assign last_o   = active_q && (count_q == AW'(DEPTH - 1));

endmodule

// File: rtl/sdft_scheduler.sv
// Sliding-DFT scheduler: sample ring upkeep, per-sample update sweeps and
// periodic spectrum readout from the bin RAM.
module sdft_scheduler
  import sdft_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int unsigned FFT_SIZE   = DEF_FFT_SIZE,
  parameter int unsigned FRAME_HOP  = DEF_FRAME_HOP,
  localparam int unsigned AW = addr_width(FFT_SIZE),
  localparam int unsigned DW = diff_width(WORD_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WORD_WIDTH-1:0] s_data,
  output logic [AW-1:0]         ring_addr,
  input  logic [WORD_WIDTH-1:0] ring_rd_data,
  output logic                  ring_wr_en,
  output logic [WORD_WIDTH-1:0] ring_wr_data,
  output logic                  upd_start,
  output logic [DW-1:0]         upd_diff,
  input  logic                  upd_done,
  output logic                  bin_sel,
  output logic [AW-1:0]         bin_addr,
  output logic                  bin_clr,
  output logic                  bin_rd_en,
  output logic                  frame_valid,
  output logic [AW-1:0]         frame_idx,
  output logic                  frame_last
);

  localparam int unsigned HW = AW + 1;

  state_e                state_q, state_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [HW-1:0]         hop_q, hop_d;
  logic [WORD_WIDTH-1:0] sample_q, sample_d;
  logic [DW-1:0]         diff_q, diff_d;
  logic                  upd_start_q, upd_start_d;
  logic                  bin_sel_q, bin_sel_d;
  logic                  fvalid_q;
  logic [AW-1:0]         fidx_q;
  logic                  flast_q;

  logic                  cnt_start;
  logic                  cnt_active;
  logic [AW-1:0]         cnt_count;
  logic                  cnt_last;

  sdft_sweep_counter #(
    .DEPTH (FFT_SIZE),
    .AW    (AW)
  ) u_sweep (
    .clk_i    (clk),
    .rst_ni   (reset_n),
    .start_i  (cnt_start),
    .active_o (cnt_active),
    .count_o  (cnt_count),
    .last_o   (cnt_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= INIT;
      wr_ptr_q    <= '0;
      hop_q       <= '0;
      sample_q    <= '0;
      diff_q      <= '0;
      upd_start_q <= 1'b0;
      bin_sel_q   <= 1'b1;
      fvalid_q    <= 1'b0;
      fidx_q      <= '0;
      flast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      hop_q       <= hop_d;
      sample_q    <= sample_d;
      diff_q      <= diff_d;
      upd_start_q <= upd_start_d;
      bin_sel_q   <= bin_sel_d;
      // Frame strobes lag the read address by one cycle to line up with RAM data.
      fvalid_q    <= bin_rd_en;
      fidx_q      <= cnt_count;
      flast_q     <= bin_rd_en && cnt_last;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    hop_d        = hop_q;
    sample_d     = sample_q;
    diff_d       = diff_q;
    upd_start_d  = 1'b0;
    bin_sel_d    = bin_sel_q;
    cnt_start    = 1'b0;
    s_ready      = 1'b0;
    ring_addr    = wr_ptr_q;
    ring_wr_en   = 1'b0;
    ring_wr_data = sample_q;
    bin_clr      = 1'b0;
    bin_rd_en    = 1'b0;

    case (state_q)
      INIT: begin
        // The sweep is idle on the first cycle out of reset; kick it, then clear.
        ring_addr    = cnt_count;
        ring_wr_data = '0;
        if (!cnt_active) begin
          cnt_start = 1'b1;
        end else begin
          ring_wr_en = 1'b1;
          bin_clr    = 1'b1;
          if (cnt_last) begin
            bin_sel_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end

      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          sample_d = s_data;
          state_d  = FETCH;
        end
      end

      FETCH: begin
        ring_wr_en  = 1'b1;
        diff_d      = $signed({sample_q[WORD_WIDTH-1], sample_q})
                    - $signed({ring_rd_data[WORD_WIDTH-1], ring_rd_data});
        wr_ptr_d    = wr_ptr_q + 1'b1;
        upd_start_d = 1'b1;
        state_d     = WAIT_UPD;
      end

      WAIT_UPD: begin
        // A done coinciding with the launch pulse belongs to no sweep of ours.
        if (upd_done && !upd_start_q) begin
          if (hop_q == HW'(FRAME_HOP - 1)) begin
            hop_d     = '0;
            bin_sel_d = 1'b1;
            cnt_start = 1'b1;
            state_d   = READOUT;
          end else begin
            hop_d   = hop_q + 1'b1;
            state_d = IDLE;
          end
        end
      end

      READOUT: begin
        if (cnt_active) begin
          bin_rd_en = 1'b1;
          if (cnt_last) begin
            bin_sel_d = 1'b0;
            state_d   = IDLE;
          end
        end else begin
          bin_sel_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: begin
        bin_sel_d = 1'b1;
        state_d   = INIT;
      end
    endcase
  end

  assign upd_start   = upd_start_q;
  assign upd_diff    = diff_q;
  assign bin_sel     = bin_sel_q;
  assign bin_addr    = cnt_count;
  assign frame_valid = fvalid_q;
  assign frame_idx   = fidx_q;
  assign frame_last  = flast_q;

endmodule

// File: tb/tb_sdft_scheduler.sv
// Directed/random bench for sdft_scheduler with a sample-history reference model.
module tb_sdft_scheduler;

  localparam int N   = 8;
  localparam int HOP = 4;
  localparam int W   = 16;
  localparam int AW  = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_data;
  logic [AW-1:0] ring_addr;
  logic [W-1:0]  ring_rd_data;
  logic          ring_wr_en;
  logic [W-1:0]  ring_wr_data;
  logic          upd_start;
  logic [W:0]    upd_diff;
  logic          upd_done;
  logic          bin_sel;
  logic [AW-1:0] bin_addr;
  logic          bin_clr;
  logic          bin_rd_en;
  logic          frame_valid;
  logic [AW-1:0] frame_idx;
  logic          frame_last;

  logic [W-1:0]  ring_mem [N];
  logic [W-1:0]  bin_rdq;

  int n_assert = 0;
  int n_fail   = 0;
  int hist[$];
  int hop = 0;

  sdft_scheduler #(
    .WORD_WIDTH (W),
    .FFT_SIZE   (N),
    .FRAME_HOP  (HOP)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .ring_addr    (ring_addr),
    .ring_rd_data (ring_rd_data),
    .ring_wr_en   (ring_wr_en),
    .ring_wr_data (ring_wr_data),
    .upd_start    (upd_start),
    .upd_diff     (upd_diff),
    .upd_done     (upd_done),
    .bin_sel      (bin_sel),
    .bin_addr     (bin_addr),
    .bin_clr      (bin_clr),
    .bin_rd_en    (bin_rd_en),
    .frame_valid  (frame_valid),
    .frame_idx    (frame_idx),
    .frame_last   (frame_last)
  );

  always #5 clk = ~clk;

  // Sample ring: 1-cycle read latency, read returns the pre-write contents.
  always @(posedge clk) begin
    if (ring_wr_en) ring_mem[ring_addr] <= ring_wr_data;
    ring_rd_data <= ring_mem[ring_addr];
  end

  // Bin RAM stand-in: each bin reads back as index + 256.
  always @(posedge clk) begin
    if (bin_rd_en) bin_rdq <= 16'(bin_addr) + 16'd256;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_ring_wr_en", ring_wr_en, 0);
    chk("rst_upd_start", upd_start, 0);
    chk("rst_bin_clr", bin_clr, 0);
    chk("rst_bin_rd_en", bin_rd_en, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_frame_last", frame_last, 0);
    chk("rst_upd_diff", $signed(upd_diff), 0);
    chk("rst_bin_sel", bin_sel, 1);
    chk("rst_frame_idx", frame_idx, 0);
  endtask

  // Called right after reset release; follows the clear sweep to IDLE.
  task automatic init_check();
    int n;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      chk("init_clr_eq_wr", bin_clr, ring_wr_en);
      if (ring_wr_en) begin
        chk("init_ring_addr", ring_addr, n);
        chk("init_bin_addr", bin_addr, n);
        chk("init_wr_data", ring_wr_data, 0);
        chk("init_bin_sel", bin_sel, 1);
        n++;
      end
      if (s_ready) break;
    end
    chk("init_count", n, N);
    chk("init_s_ready", s_ready, 1);
    chk("init_bin_sel_end", bin_sel, 0);
    chk("init_ring_addr_idle", ring_addr, 0);
  endtask

  task automatic readout(input int abort_bin);
    int  rd_i, fv_i, lasts;
    bit  aborted;
    rd_i = 0; fv_i = 0; lasts = 0; aborted = 0;
    s_valid = 1'b1;
    s_data  = 16'h7777;
    for (int c = 0; c < 40; c++) begin
      if (frame_valid) begin
        chk("fr_idx", frame_idx, fv_i);
        chk("fr_data", bin_rdq, fv_i + 256);
        chk("fr_last", frame_last, (fv_i == N - 1) ? 1 : 0);
        if (frame_last) lasts++;
        fv_i++;
      end
      if (s_ready) break;
      if (bin_rd_en) begin
        chk("ro_bin_addr", bin_addr, rd_i);
        chk("ro_bin_sel", bin_sel, 1);
        rd_i++;
      end
      if (abort_bin >= 0 && bin_rd_en && int'(bin_addr) == abort_bin) begin
        aborted = 1;
        break;
      end
      tick();
    end
    if (aborted) begin
      reset_n = 1'b0;
      s_valid = 1'b0;
      #1;
      chk_reset_outputs();
      repeat (3) begin
        tick();
        if (frame_last) lasts++;
        chk("abort_fv_low", frame_valid, 0);
      end
      chk("abort_no_last", lasts, 0);
      chk("abort_frames_seen", fv_i, abort_bin);
      hist.delete();
      hop = 0;
      reset_n = 1'b1;
      init_check();
    end else begin
      chk("ro_rd_count", rd_i, N);
      chk("ro_fv_count", fv_i, N);
      chk("ro_last_count", lasts, 1);
      chk("ro_end_ready", s_ready, 1);
      chk("ro_end_bin_sel", bin_sel, 0);
    end
  endtask

  task automatic send(input int v, input bit early, input int dly, input int abort_bin);
    int oldest, exp_diff, exp_addr;
    oldest   = (hist.size() >= N) ? hist[hist.size() - N] : 0;
    exp_diff = v - oldest;
    exp_addr = hist.size() % N;
    s_valid = 1'b1;
    s_data  = W'(v);
    for (int c = 0; c < 40; c++) begin
      if (s_ready) break;
      tick();
    end
    chk("acc_ready", s_ready, 1);
    chk("acc_ring_addr", ring_addr, exp_addr);
    chk("acc_bin_sel", bin_sel, 0);
    tick();
    s_valid = 1'b0;
    chk("fetch_ready", s_ready, 0);
    chk("fetch_wr_en", ring_wr_en, 1);
    chk("fetch_wr_data", $signed(ring_wr_data), v);
    chk("fetch_ring_addr", ring_addr, exp_addr);
    chk("fetch_upd_start", upd_start, 0);
    hist.push_back(v);
    tick();
    chk("upd_start", upd_start, 1);
    chk("upd_diff", $signed(upd_diff), exp_diff);
    chk("wait_wr_en", ring_wr_en, 0);
    if (early) upd_done = 1'b1;
    tick();
    upd_done = 1'b0;
    chk("start_pulse", upd_start, 0);
    chk("wait_ready", s_ready, 0);
    for (int i = 0; i < dly; i++) begin
      chk("hold_diff", $signed(upd_diff), exp_diff);
      tick();
      chk("hold_ready", s_ready, 0);
    end
    upd_done = 1'b1;
    tick();
    upd_done = 1'b0;
    hop++;
    if (hop == HOP) begin
      hop = 0;
      chk("ro_entry_bin_sel", bin_sel, 1);
      chk("ro_entry_ready", s_ready, 0);
      readout(abort_bin);
    end else begin
      chk("idle_ready", s_ready, 1);
      chk("idle_bin_sel", bin_sel, 0);
    end
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(65535, 0)) - 32768;
  endfunction

  initial begin
    reset_n  = 1'b1;
    s_valid  = 1'b0;
    s_data   = '0;
    upd_done = 1'b0;
    #2;
    reset_n = 1'b0;
    tick();
    tick();
    chk_reset_outputs();
    reset_n = 1'b1;
    init_check();

    send(100, 1'b1, 2, -1);
    chk("ring0_after_first", $signed(ring_mem[0]), 100);
    repeat (3) send(rnd_sample(), 1'($urandom_range(1, 0)), int'($urandom_range(3, 0)), -1);

    send(32767, 1'b0, 1, -1);
    send(-32768, 1'b0, 0, -1);
    repeat (6) send(rnd_sample(), 1'b0, int'($urandom_range(2, 0)), -1);
    send(-32768, 1'b1, 1, -1);
    send(32767, 1'b0, 2, -1);

    while (hop != HOP - 1) send(rnd_sample(), 1'b0, 0, -1);
    send(rnd_sample(), 1'b0, 1, 3);

    for (int k = 1; k <= 9; k++) send(k, 1'b0, int'($urandom_range(2, 0)), -1);

    repeat (12) send(rnd_sample(), 1'($urandom_range(1, 0)), int'($urandom_range(3, 0)), -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
